// File: rtl/tempo_generator_pkg.sv
// Shared constants for the tempo generator: reset defaults and config register select codes.
package tempo_generator_pkg;
    localparam int   DEF_PERIOD = 5000000;
    localparam int   DEF_BAR    = 4;
    localparam logic CFG_PERIOD = 1'b0;
    localparam logic CFG_BAR    = 1'b1;
endpackage

// File: rtl/tempo_channel.sv
// One tempo channel: period counter, beat index within a bar, and registered tick/downbeat pulses.
module tempo_channel #(
    parameter int CNT_W      = 32,
    parameter int BEAT_W     = 4,
    parameter int DEF_PERIOD = 5000000,
    parameter int DEF_BAR    = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              run,
    input  logic              pause,
    input  logic              per_we,
    input  logic              bar_we,
    input  logic [CNT_W-1:0]  cfg_data,
    output logic              tick,
    output logic              downbeat,
    output logic [BEAT_W-1:0] beat
);
    logic [CNT_W-1:0]  cnt_p1;
    logic [CNT_W-1:0]  per_p1;
    logic [BEAT_W-1:0] beat_p1;
    logic [BEAT_W-1:0] bar_p1;
    logic              tick_p1;
    logic              downbeat_p1;
    logic              wrap_c;

    // A bar length of zero means free-running beats that never mark a downbeat.
    function automatic logic bar_end(input logic [BEAT_W-1:0] b, input logic [BEAT_W-1:0] len);
        return (len != '0) && (b >= len - BEAT_W'(1));
    endfunction

    function automatic logic [BEAT_W-1:0] next_beat(input logic [BEAT_W-1:0] b,
                                                    input logic [BEAT_W-1:0] len);
        return bar_end(b, len) ? '0 : b + BEAT_W'(1);
    endfunction

    // >= rather than == so a shrunken period wraps at once instead of overrunning.
    assign wrap_c = (per_p1 != '0) && (cnt_p1 >= per_p1 - CNT_W'(1));

    // Stage p1: counter, beat and pulse registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_p1      <= '0;
            beat_p1     <= '0;
            tick_p1     <= 1'b0;
            downbeat_p1 <= 1'b0;
            per_p1      <= CNT_W'(DEF_PERIOD);
            bar_p1      <= BEAT_W'(DEF_BAR);
        end else begin
            if (per_we) per_p1 <= cfg_data;
            if (bar_we) bar_p1 <= cfg_data[BEAT_W-1:0];
            tick_p1     <= 1'b0;
            downbeat_p1 <= 1'b0;
            if (!run) begin
                cnt_p1  <= '0;
                beat_p1 <= '0;
            end else if (!pause) begin
                if (per_p1 == '0) begin
                    cnt_p1 <= '0;
                end else if (wrap_c) begin
                    cnt_p1      <= '0;
                    tick_p1     <= 1'b1;
                    beat_p1     <= next_beat(beat_p1, bar_p1);
                    downbeat_p1 <= bar_end(beat_p1, bar_p1);
                end else begin
                    cnt_p1 <= cnt_p1 + CNT_W'(1);
                end
            end
        end
    end

    assign tick     = tick_p1;
    assign downbeat = downbeat_p1;
    assign beat     = beat_p1;
endmodule

// File: rtl/tempo_generator.sv
// Multi-channel tempo generator: decodes config writes to channels and packs their outputs.
module tempo_generator #(
    parameter int NUM_CH     = 2,
    parameter int CNT_W      = 32,
    parameter int BEAT_W     = 4,
    parameter int DEF_PERIOD = tempo_generator_pkg::DEF_PERIOD,
    parameter int DEF_BAR    = tempo_generator_pkg::DEF_BAR
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NUM_CH-1:0]        run,
    input  logic [NUM_CH-1:0]        pause,
    input  logic                     cfg_we,
    input  logic [2:0]               cfg_ch,
    input  logic                     cfg_sel,
    input  logic [CNT_W-1:0]         cfg_data,
    output logic [NUM_CH-1:0]        tick,
    output logic [NUM_CH-1:0]        downbeat,
    output logic [NUM_CH*BEAT_W-1:0] beat_idx
);
    import tempo_generator_pkg::*;

    // Channel numbers at or above NUM_CH match no instance, so such writes drop silently.
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic per_we;
        logic bar_we;

        assign per_we = cfg_we && (cfg_sel == CFG_PERIOD) && (cfg_ch == 3'(c));
        assign bar_we = cfg_we && (cfg_sel == CFG_BAR) && (cfg_ch == 3'(c));

        tempo_channel #(
            .CNT_W      (CNT_W),
            .BEAT_W     (BEAT_W),
            .DEF_PERIOD (DEF_PERIOD),
            .DEF_BAR    (DEF_BAR)
        ) u_channel (
            .clock    (clock),
            .reset    (reset),
            .run      (run[c]),
            .pause    (pause[c]),
            .per_we   (per_we),
            .bar_we   (bar_we),
            .cfg_data (cfg_data),
            .tick     (tick[c]),
            .downbeat (downbeat[c]),
            .beat     (beat_idx[c*BEAT_W +: BEAT_W])
        );
    end
endmodule
